muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle iterative multiply/divide unit for the RV32IM datapath. It executes the eight M-extension operations with a start/done handshake instead of combinational arrays.
- It takes the same 5-bit ALU control encodings: OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPDIVU, OPREM, OPREMU.
- It sits beside the ALU in the multicycle core. The core control FSM stalls on oBusy and captures oResult when oDone pulses.

Parameters:
- XLEN, 32, operand and result width; only 32 is verified.

Ports:
- iCLK  input  1  clock; all state changes on the rising edge.
- iRST  input  1  synchronous, active-high reset.
- iStart  input  1  request pulse; sampled only when oBusy=0.
- iControl  input  5  operation code using the shared ALU op encodings.
- iA  input  32  operand A (rs1); dividend for div/rem.
- iB  input  32  operand B (rs2); divisor for div/rem.
- oBusy  output  1  high while an operation is in flight.
- oDone  output  1  one-cycle pulse; oResult is valid in this cycle.
- oResult  output  32  result; holds its value until the next accepted start.

Behaviour:
- Reset (iCLK edge with iRST=1): state goes to IDLE; oBusy=0, oDone=0, oResult=0, counter=0. Reset has priority over iStart.
- Reset mid-operation aborts the operation. No oDone pulse is produced and the partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - Edge N with iStart=1 accepts the request: iControl, iA and iB are latched; sign flags and magnitudes are computed; counter is loaded with 32.
  - State moves to CALC and oBusy=1 from the cycle after edge N.
  - iStart=0 stays in IDLE with oDone=0.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on magnitudes giving a 32-bit quotient and remainder.
  - The counter decrements each cycle; when it reaches 0, sign fix-up and result select are applied and state moves to DONE.
- DONE:
  - oDone=1 and oResult is valid for exactly one cycle. oBusy=0 in DONE.
  - State returns to IDLE on the next edge.
  - iStart during DONE is ignored.
- Fixed latency: oDone is high in the cycle following the 33rd rising edge after the accepting edge N. There is no early-out and special cases do not shorten the latency.
- iStart is ignored while oBusy=1, and operands presented during CALC have no effect.
- Back-to-back operation: the earliest next accept is the IDLE edge after DONE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply results:
  - The 64-bit product is negated when the operand signs differ.
  - MUL returns product[31:0].
  - MULH, MULHU and MULHSU return product[63:32].
- Divide results:
  - The quotient is negated when sign(A) xor sign(B), for signed ops only.
  - The remainder takes the sign of A (signed ops); |rem| < |B|.
- Divide by zero (iB=0):
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return iA unchanged.
- Signed overflow (iA=0x80000000, iB=0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- Any non-M iControl value (including OPNULL) completes with the same latency and oResult=0.

Test Plan:
- Reset then idle: iRST=1 for 2 cycles -> oBusy=0, oDone=0, oResult=0. Then iStart=0 for 50 cycles -> no oDone.
- MUL/MULH: iA=0xFFFFFFFE (-2), iB=0x00000003.
  - MUL -> 0xFFFFFFFA.
  - MULH -> 0xFFFFFFFF.
  - MULHU -> 0x00000002.
  - MULHSU -> 0xFFFFFFFF.
  - In every case oDone pulses exactly 33 edges after the accepting edge.
- DIV/REM signs: iA=-7 (0xFFFFFFF9), iB=2.
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 0x00000001.
- Corner cases:
  - DIVU with iA=5, iB=0 -> 0xFFFFFFFF.
  - REM with iA=5, iB=0 -> 5.
  - DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - iStart held high continuously with changing operands -> each op uses the operands latched at its own accept.
  - Accepts are 35 edges apart, and oDone has exactly one pulse per op.
- Reset mid-op: assert iRST at CALC cycle 10 of a DIV.
  - oBusy=0 on the next cycle and no oDone is produced.
  - A following MUL 6*7 returns 0x0000002A.

Source files
------------

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative multiply/divide unit for the RV32IM multicycle datapath. It runs
// the eight M-extension operations one bit per clock: shift-add for products
// and restoring shift-subtract for quotient/remainder. It uses a start/done
// handshake, and every operation has the same fixed latency.
//
// Ports
//   iCLK      clock, all state changes on the rising edge
//   iRST      synchronous active-high reset, has priority over iStart
//   iStart    request pulse, sampled only while idle
//   iControl  5-bit ALU operation code (shared ALU encodings)
//   iA        operand A (rs1), dividend for div/rem
//   iB        operand B (rs2), divisor for div/rem
//   oBusy     high while an operation is being computed
//   oDone     one-cycle pulse, oResult is valid in that cycle
//   oResult   result, held until overwritten by the next completion
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iStart,
    input  logic [4:0]      iControl,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    // Operation codes, mirroring the ALU control encodings of the core.
    localparam logic [4:0] OPNULL   = 5'd0;
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;

    localparam int COUNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [4:0]        op;
    logic              a_neg;
    logic              res_neg;
    logic              b_zero;
    logic [XLEN-1:0]   operand_b;
    logic [2*XLEN-1:0] acc;
    logic [COUNT_W-1:0] count;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;

    logic              signed_a;
    logic              signed_b;
    logic              in_a_neg;
    logic              in_b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic              op_is_mul;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   fix_result;

    // Decode the signedness of the incoming request and form operand
    // magnitudes. The most negative value maps onto itself, and read as an
    // unsigned number that is its correct magnitude.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (iControl)
            OPMUL, OPMULH, OPDIV, OPREM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OPMULHSU: signed_a = 1'b1;
            default: ;
        endcase
        in_a_neg = signed_a & iA[XLEN-1];
        in_b_neg = signed_b & iB[XLEN-1];
        mag_a    = in_a_neg ? (~iA + 1'b1) : iA;
        mag_b    = in_b_neg ? (~iB + 1'b1) : iB;
    end

    // One iteration step. For a multiply, acc holds {partial high, multiplier
    // bits still to consume}. For a divide, acc holds {partial remainder,
    // dividend bits still to bring down / quotient bits produced}. The remainder
    // is always below the divisor, so the 33-bit difference gives its borrow in
    // the top bit.
    always_comb begin
        op_is_mul = (op == OPMUL) || (op == OPMULH) ||
                    (op == OPMULHSU) || (op == OPMULHU);
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} +
                    (acc[0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand_b};
    end

    // Sign fix-up and result selection after the last iteration. A divide by
    // zero leaves quotient all-ones and remainder |A|, so REM needs only the
    // normal sign fix-up to return A. A signed DIV by zero must not be negated.
    // Signed overflow also falls out naturally: 0x80000000 / 1 negated is
    // 0x80000000 with remainder 0.
    always_comb begin
        product    = res_neg ? (~acc + 1'b1) : acc;
        quotient   = res_neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        remainder  = a_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op)
            OPMUL:                      fix_result = product[XLEN-1:0];
            OPMULH, OPMULHSU, OPMULHU:  fix_result = product[2*XLEN-1:XLEN];
            OPDIV, OPDIVU:              fix_result = b_zero ? {XLEN{1'b1}} : quotient;
            OPREM, OPREMU:              fix_result = remainder;
            default:                    fix_result = '0;
        endcase
    end

    // Control FSM and datapath registers. The counter is loaded with XLEN on
    // accept, counts down once per iteration, and the cycle after it reaches
    // zero applies the fix-up. This gives a fixed latency with no early-out.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            op        <= OPNULL;
            a_neg     <= 1'b0;
            res_neg   <= 1'b0;
            b_zero    <= 1'b0;
            operand_b <= '0;
            acc       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (iStart) begin
                        op        <= iControl;
                        a_neg     <= in_a_neg;
                        res_neg   <= in_a_neg ^ in_b_neg;
                        b_zero    <= (iB == '0);
                        operand_b <= mag_b;
                        acc       <= {{XLEN{1'b0}}, mag_a};
                        count     <= COUNT_W'(XLEN);
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                        if (op_is_mul) begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end else if (!div_diff[XLEN]) begin
                            acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        result <= fix_result;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign oBusy   = busy;
    assign oDone   = done;
    assign oResult = result;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed self-checking bench for muldiv_seq. Each vector carries a
// hand-computed expected result. It also checks the fixed 33-edge latency,
// the single-cycle done pulse, the held result, back-to-back handshaking and
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    localparam logic [4:0] OPNULL   = 5'd0;
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [4:0]  iControl;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult;

    int vectors_applied;
    int miscompares;

    muldiv_seq #(.XLEN(32)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iStart   (iStart),
        .iControl (iControl),
        .iA       (iA),
        .iB       (iB),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oResult  (oResult)
    );

    // 100 MHz clock.
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Guard against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one operation from idle (called #1 after a rising edge). Checks
    // busy after accept, the latency to done, the result, done being a single
    // cycle and the result being held. It returns #1 after the edge that
    // brings the unit back to idle.
    task automatic applyStimulus(input string tag, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected);
        int  lat;
        bit  seen;
        iControl = op;
        iA       = a;
        iB       = b;
        iStart   = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iA     = ~a;
        iB     = ~b;
        checkOutput({tag, "_busy"}, {31'd0, oBusy}, 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge iCLK);
            #1;
            lat++;
            if (oDone) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
        checkOutput({tag, "_result"}, oResult, expected);
        checkOutput({tag, "_busy_in_done"}, {31'd0, oBusy}, 32'd0);
        @(posedge iCLK);
        #1;
        checkOutput({tag, "_done_width"}, {31'd0, oDone}, 32'd0);
        checkOutput({tag, "_hold"}, oResult, expected);
    endtask

    initial begin
        int done_count;
        int accepts;
        int last_accept;
        bit prev_busy;
        bit pending;
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        logic [31:0] exp_prod;

        vectors_applied = 0;
        miscompares     = 0;
        iRST     = 1'b1;
        iStart   = 1'b0;
        iControl = OPNULL;
        iA       = '0;
        iB       = '0;

        // Reset and idle behaviour.
        repeat (2) @(posedge iCLK);
        #1;
        checkOutput("reset_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("reset_done", {31'd0, oDone}, 32'd0);
        checkOutput("reset_result", oResult, 32'd0);
        iRST = 1'b0;
        done_count = 0;
        repeat (50) begin
            @(posedge iCLK);
            #1;
            if (oDone) done_count++;
        end
        checkOutput("idle_no_done", 32'(done_count), 32'd0);

        // Multiply family: -2 * 3.
        applyStimulus("mul",    OPMUL,    32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA);
        applyStimulus("mulh",   OPMULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
        applyStimulus("mulhu",  OPMULHU,  32'hFFFFFFFE, 32'h00000003, 32'h00000002);
        applyStimulus("mulhsu", OPMULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

        // Divide family: -7 and 2.
        applyStimulus("div",  OPDIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        applyStimulus("rem",  OPREM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        applyStimulus("divu", OPDIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC);
        applyStimulus("remu", OPREMU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001);

        // Corner cases: divide by zero and signed overflow.
        applyStimulus("divu_by0", OPDIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF);
        applyStimulus("rem_by0",  OPREM,  32'h00000005, 32'h00000000, 32'h00000005);
        applyStimulus("div_by0_neg", OPDIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF);
        applyStimulus("rem_by0_neg", OPREM, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9);
        applyStimulus("div_ovf",  OPDIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        applyStimulus("rem_ovf",  OPREM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        // A non-M code completes with a zero result after a nonzero one.
        applyStimulus("mul_big", OPMUL, 32'h00012345, 32'h00000100, 32'h01234500);
        applyStimulus("nonm",    OPNULL, 32'h00000009, 32'h00000009, 32'h00000000);

        // Handshake: start held high while operands change every cycle. Each
        // op must use the operands present at its own accepting edge.
        iControl    = OPMUL;
        iA          = 32'd100;
        iB          = 32'd3;
        iStart      = 1'b1;
        prev_busy   = 1'b0;
        pending     = 1'b0;
        accepts     = 0;
        done_count  = 0;
        last_accept = 0;
        exp_prod    = '0;
        for (int cyc = 0; cyc < 105; cyc++) begin
            prev_a = iA;
            prev_b = iB;
            @(posedge iCLK);
            #1;
            if (oBusy && !prev_busy) begin
                if (accepts > 0) checkOutput("hs_spacing", 32'(cyc - last_accept), 32'd35);
                last_accept = cyc;
                exp_prod    = prev_a * prev_b;
                accepts++;
                pending     = 1'b1;
            end
            if (oDone) begin
                checkOutput("hs_result", oResult, exp_prod);
                checkOutput("hs_done_pending", {31'd0, pending}, 32'd1);
                pending = 1'b0;
                done_count++;
            end
            prev_busy = oBusy;
            iA = 32'd101 + 32'(cyc);
            iB = 32'd4 + 32'(cyc % 7);
        end
        iStart = 1'b0;
        checkOutput("hs_accepts", 32'(accepts), 32'd3);
        checkOutput("hs_dones", 32'(done_count), 32'd3);

        // Reset during the tenth CALC cycle of a divide.
        iControl = OPDIV;
        iA       = 32'd100;
        iB       = 32'd7;
        iStart   = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        repeat (10) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        checkOutput("midreset_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("midreset_done", {31'd0, oDone}, 32'd0);
        checkOutput("midreset_result", oResult, 32'd0);
        done_count = 0;
        repeat (40) begin
            @(posedge iCLK);
            #1;
            if (oDone) done_count++;
        end
        checkOutput("midreset_no_done", 32'(done_count), 32'd0);
        applyStimulus("after_reset_mul", OPMUL, 32'd6, 32'd7, 32'h0000002A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
